// File: rtl/edge_ctrl_pkg.sv
// rtl/edge_ctrl_pkg.sv - shared types and widths for the Sobel window sequencer
package edge_ctrl_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 9 * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/edge_window_controller_regs.sv
// rtl/edge_window_controller_regs.sv - 3x3 pixel window with column shift and slot load
module edge_window_regs
  import edge_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             shift,
  input  logic             load,
  input  logic [1:0]       load_row,
  input  logic [1:0]       load_col,
  input  logic [PIX_W-1:0] load_data,
  output logic [WIN_W-1:0] win_data
);

  // Element k is Pk; row-major, so slot = row*3 + col.
  logic [8:0][PIX_W-1:0] pix;
  logic [3:0]            slot;

  // Slot index of the pixel arriving from the image memory.
  always_comb begin
    slot = {2'b00, load_row} * 4'd3 + {2'b00, load_col};
  end

  // Shift drops the leftmost column so only the new right column must be read;
  // shift and load never coincide because shift happens in WRITE, loads in FETCH/LOAD.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix <= '0;
    end else if (shift) begin
      pix[0] <= pix[1];
      pix[1] <= pix[2];
      pix[3] <= pix[4];
      pix[4] <= pix[5];
      pix[6] <= pix[7];
      pix[7] <= pix[8];
    end else if (load) begin
      pix[slot] <= load_data;
    end
  end

  assign win_data = pix;

endmodule

// File: rtl/edge_window_controller.sv
// rtl/edge_window_controller.sv - frame sequencer feeding 3x3 windows to the Sobel engine
module edge_window_controller
  import edge_ctrl_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [WIN_W-1:0]  win_data,
  output logic              grad_start,
  input  logic              grad_ready,
  input  logic [PIX_W-1:0]  grad_sum,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IMG_W);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] row, col, out_addr;
  logic [1:0]        row_off, col_off;
  logic              pend_valid;
  logic [1:0]        pend_row, pend_col;
  logic [PIX_W-1:0]  sum_q;
  logic              last_read, last_col, last_win;

  assign last_read = (row_off == 2'd2) && (col_off == 2'd2);
  assign last_col  = (col == LAST_COL);
  assign last_win  = last_col && (row == LAST_ROW);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    grad_start = 1'b0;
    wr_en      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (last_read) state_nx = S_LOAD;
      end
      S_LOAD:  begin
        busy     = 1'b1;
        state_nx = S_START;
      end
      // Hold off while the engine still shows the previous result.
      S_START: begin
        busy = 1'b1;
        if (!grad_ready) begin
          grad_start = 1'b1;
          state_nx   = S_WAIT;
        end
      end
      S_WAIT:  begin
        busy = 1'b1;
        if (grad_ready) state_nx = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        wr_en    = 1'b1;
        state_nx = last_win ? S_DONE : S_FETCH;
      end
      S_DONE:  begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Window position, read offsets within the window, result address and captured sum.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row      <= '0;
      col      <= '0;
      out_addr <= '0;
      row_off  <= '0;
      col_off  <= '0;
      sum_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          row      <= '0;
          col      <= '0;
          out_addr <= '0;
          row_off  <= '0;
          col_off  <= '0;
        end
        S_FETCH: begin
          if (row_off == 2'd2) begin
            row_off <= '0;
            if (col_off != 2'd2) col_off <= col_off + 2'd1;
          end else begin
            row_off <= row_off + 2'd1;
          end
        end
        S_WAIT: if (grad_ready) sum_q <= grad_sum;
        S_WRITE: begin
          out_addr <= out_addr + 1'b1;
          row_off  <= '0;
          if (last_col) begin
            col     <= '0;
            row     <= row + 1'b1;
            col_off <= 2'd0;
          end else begin
            col     <= col + 1'b1;
            col_off <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  // Remember which slot each read targets; its data shows up one cycle later.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_valid <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
    end else begin
      pend_valid <= rd_en;
      pend_row   <= row_off;
      pend_col   <= col_off;
    end
  end

  assign rd_addr = rd_en ? (row + ADDR_W'(row_off)) * ROW_PITCH + col + ADDR_W'(col_off) : '0;
  assign wr_addr = wr_en ? out_addr : '0;
  assign wr_data = wr_en ? sum_q : '0;

  edge_window_regs u_regs (
    .clk       (clk),
    .n_rst     (n_rst),
    .shift     (wr_en && !last_col),
    .load      (pend_valid),
    .load_row  (pend_row),
    .load_col  (pend_col),
    .load_data (rd_data),
    .win_data  (win_data)
  );

endmodule

// File: tb/tb_edge_window_controller.sv
// tb/tb_edge_window_controller.sv - randomized self-checking bench for edge_window_controller
module tb_edge_window_controller;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] grad_sum = 8'h00;
  logic grad_ready = 1'b0;

  always #5 clk = ~clk;

  logic busy3, done3, rd_en3, gs3, wr_en3;
  logic [15:0] rd_addr3, wr_addr3;
  logic [71:0] win3;
  logic [7:0] wr_data3;
  logic busy4, done4, rd_en4, gs4, wr_en4;
  logic [15:0] rd_addr4, wr_addr4;
  logic [71:0] win4;
  logic [7:0] wr_data4;

  edge_window_controller #(.IMG_W(3), .IMG_H(3), .ADDR_W(16)) u_dut3 (
    .clk(clk), .n_rst(n_rst), .start(start & ~sel), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data), .win_data(win3),
    .grad_start(gs3), .grad_ready(grad_ready), .grad_sum(grad_sum),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3)
  );

  edge_window_controller #(.IMG_W(4), .IMG_H(4), .ADDR_W(16)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .start(start & sel), .busy(busy4), .done(done4),
    .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data), .win_data(win4),
    .grad_start(gs4), .grad_ready(grad_ready), .grad_sum(grad_sum),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4)
  );

  wire        m_busy    = sel ? busy4 : busy3;
  wire        m_done    = sel ? done4 : done3;
  wire        m_rd_en   = sel ? rd_en4 : rd_en3;
  wire [15:0] m_rd_addr = sel ? rd_addr4 : rd_addr3;
  wire [71:0] m_win     = sel ? win4 : win3;
  wire        m_gs      = sel ? gs4 : gs3;
  wire        m_wr_en   = sel ? wr_en4 : wr_en3;
  wire [15:0] m_wr_addr = sel ? wr_addr4 : wr_addr3;
  wire [7:0]  m_wr_data = sel ? wr_data4 : wr_data3;

  logic [7:0] img[$];
  int eng_delay = 20;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sobel9(input int p[9]);
    int gx, gy, s;
    gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
    gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int sobel_at(input int r, input int c, input int w);
    int p[9];
    for (int i = 0; i < 9; i++) p[i] = int'(img[(r + i / 3) * w + c + i % 3]);
    return sobel9(p);
  endfunction

  function automatic logic [71:0] win_at(input int r, input int c, input int w);
    logic [71:0] e;
    e = '0;
    for (int k = 8; k >= 0; k--) e = (e << 8) | 72'(img[(r + k / 3) * w + c + k % 3]);
    return e;
  endfunction

  // Image memory: one-cycle read latency.
  always @(posedge clk) begin
    int a;
    a = int'(m_rd_addr);
    rd_data <= (m_rd_en && a < img.size()) ? img[a] : 8'h00;
  end

  // Engine model: result ready eng_delay cycles after grad_start, held two cycles.
  int eng_t = 0;
  logic [7:0] eng_sum = 8'h00;
  always @(posedge clk or negedge n_rst) begin
    int p[9];
    logic [71:0] wv;
    if (!n_rst) begin
      eng_t <= 0;
      grad_ready <= 1'b0;
      grad_sum <= 8'h00;
    end else if (m_gs) begin
      wv = m_win;
      for (int k = 0; k < 9; k++) begin
        p[k] = int'(wv[7:0]);
        wv = wv >> 8;
      end
      eng_sum <= 8'(sobel9(p));
      eng_t <= 1;
      grad_ready <= 1'b0;
      grad_sum <= 8'h00;
    end else if (eng_t > 0) begin
      eng_t <= (eng_t + 1 > eng_delay + 1) ? 0 : eng_t + 1;
      grad_ready <= (eng_t + 1 == eng_delay) || (eng_t + 1 == eng_delay + 1);
      grad_sum <= ((eng_t + 1 == eng_delay) || (eng_t + 1 == eng_delay + 1)) ? eng_sum : 8'h00;
    end else begin
      grad_ready <= 1'b0;
      grad_sum <= 8'h00;
    end
  end

  // Event logs sampled mid-cycle.
  int rd_addr_q[$], rd_cyc_q[$], gs_cyc_q[$], rdy_cyc_q[$];
  int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], done_cyc_q[$], busy_at_done_q[$];
  logic [71:0] gs_win_q[$];
  logic [71:0] held_win = '0;
  logic in_wait = 1'b0;
  logic prev_rdy = 1'b0;
  int win_moved = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      in_wait = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (m_rd_en) begin
        rd_addr_q.push_back(int'(m_rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (m_gs) begin
        gs_cyc_q.push_back(cyc);
        gs_win_q.push_back(m_win);
        held_win = m_win;
        in_wait = 1'b1;
      end else if (in_wait && m_win !== held_win) begin
        win_moved++;
      end
      if (grad_ready && !prev_rdy) rdy_cyc_q.push_back(cyc);
      prev_rdy = grad_ready;
      if (m_wr_en) begin
        wr_addr_q.push_back(int'(m_wr_addr));
        wr_data_q.push_back(int'(m_wr_data));
        wr_cyc_q.push_back(cyc);
        in_wait = 1'b0;
      end
      if (m_done) begin
        done_cyc_q.push_back(cyc);
        busy_at_done_q.push_back(int'(m_busy));
      end
    end
  end

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete(); gs_cyc_q.delete(); rdy_cyc_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete(); busy_at_done_q.delete(); gs_win_q.delete();
    win_moved = 0;
    in_wait = 1'b0;
  endtask

  task automatic set_image(input int w, input int h, input int mode);
    img.delete();
    for (int i = 0; i < w * h; i++) begin
      case (mode)
        0:       img.push_back(8'(i));
        1:       img.push_back(8'(i * 17));
        default: img.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  task automatic run_frame(input int poke_busy, input int poke_done, output int t);
    int n;
    @(negedge clk); #1;
    check("busy_before_start", 72'(m_busy), 72'(0));
    start = 1'b1;
    t = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_t1", 72'(m_busy), 72'(1));
    if (poke_busy > 0) begin
      repeat (poke_busy) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!m_done && n < 3000);
    if (!m_done) check("frame_timeout", 72'(0), 72'(1));
    if (poke_done != 0 && m_done) begin
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic check_frame(input int t, input int w, input int h);
    int er[$], ec[$];
    int nwin, k, base, e;
    nwin = (w - 2) * (h - 2);
    k = 0;
    for (int r = 0; r < h - 2; r++) begin
      for (int c = 0; c < w - 2; c++) begin
        base = (k == 0) ? t + 1 : ((k - 1 < rdy_cyc_q.size()) ? rdy_cyc_q[k - 1] + 2 : -1);
        if (c == 0) begin
          for (int i = 0; i < 9; i++) begin
            er.push_back((r + i % 3) * w + i / 3);
            ec.push_back(base + i);
          end
        end else begin
          for (int i = 0; i < 3; i++) begin
            er.push_back((r + i) * w + c + 2);
            ec.push_back(base + i);
          end
        end
        k++;
      end
    end
    check("rd_count", 72'(rd_addr_q.size()), 72'(er.size()));
    for (int i = 0; i < er.size() && i < rd_addr_q.size(); i++) begin
      check("rd_addr", 72'(rd_addr_q[i]), 72'(er[i]));
      check("rd_cycle", 72'(rd_cyc_q[i]), 72'(ec[i]));
    end
    check("gs_count", 72'(gs_cyc_q.size()), 72'(nwin));
    check("wr_count", 72'(wr_addr_q.size()), 72'(nwin));
    for (int i = 0; i < nwin; i++) begin
      int r, c;
      r = i / (w - 2);
      c = i % (w - 2);
      if (i < gs_cyc_q.size()) begin
        check("win_data", gs_win_q[i], win_at(r, c, w));
        if (i == 0) e = t + 11;
        else e = (i - 1 < rdy_cyc_q.size()) ? rdy_cyc_q[i - 1] + ((c == 0) ? 12 : 6) : -1;
        check("gs_cycle", 72'(gs_cyc_q[i]), 72'(e));
      end
      if (i < wr_addr_q.size()) begin
        check("wr_addr", 72'(wr_addr_q[i]), 72'(i));
        check("wr_data", 72'(wr_data_q[i]), 72'(sobel_at(r, c, w)));
        e = (i < rdy_cyc_q.size()) ? rdy_cyc_q[i] + 1 : -1;
        check("wr_cycle", 72'(wr_cyc_q[i]), 72'(e));
      end
    end
    check("win_held_in_wait", 72'(win_moved), 72'(0));
    check("done_count", 72'(done_cyc_q.size()), 72'(1));
    if (done_cyc_q.size() > 0 && wr_cyc_q.size() > 0) begin
      check("done_cycle", 72'(done_cyc_q[0]), 72'(wr_cyc_q[wr_cyc_q.size() - 1] + 1));
      check("busy_at_done", 72'(busy_at_done_q[0]), 72'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 72'({m_busy, m_done, m_rd_en, m_gs, m_wr_en}), 72'(0));
    check({tag, "_addr"}, 72'({m_rd_addr, m_wr_addr, m_wr_data}), 72'(0));
    check({tag, "_win"}, m_win, 72'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n;
    set_image(3, 3, 0);
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("idle_busy", 72'(m_busy), 72'(0));

    // 3x3 frame of pixels 0..8
    clear_logs();
    run_frame(0, 0, t);
    check_frame(t, 3, 3);
    if (wr_data_q.size() > 0) check("sum_3x3", 72'(wr_data_q[0]), 72'(32));

    // 4x4 ramp frame
    sel = 1'b1;
    set_image(4, 4, 1);
    clear_logs();
    run_frame(0, 0, t);
    check_frame(t, 4, 4);

    // slow engine
    eng_delay = 50;
    set_image(4, 4, 2);
    clear_logs();
    run_frame(0, 0, t);
    check_frame(t, 4, 4);

    // start pulses while busy and in the done cycle
    eng_delay = 20 + int'($urandom_range(0, 5));
    set_image(4, 4, 2);
    clear_logs();
    run_frame(5, 1, t);
    check_frame(t, 4, 4);

    // reset during WAIT of window (0,1)
    eng_delay = 20;
    set_image(4, 4, 2);
    clear_logs();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    n = 0;
    while (gs_cyc_q.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_window_01", 72'(gs_cyc_q.size() >= 2), 72'(1));
    repeat (5) @(negedge clk);
    #3 n_rst = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) @(negedge clk);
    #1 n_rst = 1'b1;
    set_image(4, 4, 2);
    clear_logs();
    run_frame(0, 0, t);
    check_frame(t, 4, 4);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
